// File: rtl/pipe_hazard_ctrl_if.sv
// Decode-side hazard interface: D-stage instruction fields and events in,
// forward selects, stall/flush/hold controls and status out.
interface pipe_hazard_ctrl_if #(
  parameter int unsigned REG_W = 5,
  parameter int unsigned SEL_W = 3
);
  logic             d_valid;
  logic [REG_W-1:0] d_rs1;
  logic             d_rs1_used;
  logic [REG_W-1:0] d_rs2;
  logic             d_rs2_used;
  logic [REG_W-1:0] d_rd;
  logic             d_wr;
  logic             d_is_load;
  logic             d_is_multi;
  logic             x_redirect;
  logic             md_done;
  logic             stall_d;
  logic             flush_fd;
  logic             flush_dx;
  logic             x_hold;
  logic [SEL_W-1:0] fwd_sel_a;
  logic [SEL_W-1:0] fwd_sel_b;
  logic             md_timeout;
  logic [SEL_W:0]   inflight;

  modport master (
    output d_valid, d_rs1, d_rs1_used, d_rs2, d_rs2_used, d_rd, d_wr,
           d_is_load, d_is_multi, x_redirect, md_done,
    input  stall_d, flush_fd, flush_dx, x_hold, fwd_sel_a, fwd_sel_b,
           md_timeout, inflight
  );

  modport slave (
    input  d_valid, d_rs1, d_rs1_used, d_rs2, d_rs2_used, d_rd, d_wr,
           d_is_load, d_is_multi, x_redirect, md_done,
    output stall_d, flush_fd, flush_dx, x_hold, fwd_sel_a, fwd_sel_b,
           md_timeout, inflight
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Hazard, bypass and stall controller: shift-register scoreboard of in-flight
// destinations over DEPTH post-decode stages, driving forwards/stalls/flushes.
module pipe_hazard_ctrl #(
  parameter int unsigned NREGS  = 32,
  parameter int unsigned REG_W  = 5,
  parameter int unsigned DEPTH  = 3,
  parameter int unsigned SEL_W  = 3,
  parameter int unsigned MD_MAX = 64
) (
  input logic              clock,
  input logic              reset,
  pipe_hazard_ctrl_if.slave hz
);
  localparam int unsigned CNT_W = $clog2(MD_MAX + 1);

  typedef struct packed {
    logic             valid;
    logic [REG_W-1:0] rd;
    logic             wr;
    logic             is_load;
    logic             is_multi;
  } sb_entry_t;

  sb_entry_t        sb     [DEPTH];
  sb_entry_t        sb_nxt [DEPTH];
  logic [CNT_W-1:0] md_cnt;
  logic             md_timeout_q;
  logic [SEL_W:0]   inflight_q;
  logic [SEL_W:0]   inflight_nxt;

  logic [SEL_W-1:0] sel_a, sel_b;
  logic             found_a, found_b;
  logic             load_use, hold, redirect, stall, insert;

  function automatic logic hit(input sb_entry_t e, input logic [REG_W-1:0] s);
    return e.valid && e.wr && (e.rd == s) && (s != '0) && (32'(s) < NREGS);
  endfunction

  // Ascending scan: first hit is the youngest producer.
  always_comb begin
    sel_a   = '0;
    sel_b   = '0;
    found_a = 1'b0;
    found_b = 1'b0;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      if (!found_a && hz.d_valid && hz.d_rs1_used && hit(sb[k], hz.d_rs1)) begin
        sel_a   = SEL_W'(k + 1);
        found_a = 1'b1;
      end
      if (!found_b && hz.d_valid && hz.d_rs2_used && hit(sb[k], hz.d_rs2)) begin
        sel_b   = SEL_W'(k + 1);
        found_b = 1'b1;
      end
    end
  end

  // Hold releases either on md_done or once MD_MAX held cycles have elapsed.
  always_comb begin
    load_use = sb[0].is_load && ((sel_a == SEL_W'(1)) || (sel_b == SEL_W'(1)));
    hold     = sb[0].valid && sb[0].is_multi && !hz.md_done
               && (md_cnt != CNT_W'(MD_MAX));
    redirect = hz.x_redirect && !hold;
    stall    = hold || (load_use && !redirect);
    insert   = hz.d_valid && !stall && !redirect;
  end

  always_comb begin
    for (int unsigned k = 0; k < DEPTH; k++) sb_nxt[k] = sb[k];
    if (!hold) begin
      for (int unsigned k = 1; k < DEPTH; k++) sb_nxt[k] = sb[k-1];
      sb_nxt[0] = '0;
      if (insert) begin
        sb_nxt[0] = '{valid: 1'b1, rd: hz.d_rd, wr: hz.d_wr,
                      is_load: hz.d_is_load, is_multi: hz.d_is_multi};
      end
    end
    inflight_nxt = '0;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      if (sb_nxt[k].valid && sb_nxt[k].wr) inflight_nxt = inflight_nxt + (SEL_W+1)'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int unsigned k = 0; k < DEPTH; k++) sb[k] <= '0;
      md_cnt       <= '0;
      md_timeout_q <= 1'b0;
      inflight_q   <= '0;
    end else begin
      sb         <= sb_nxt;
      inflight_q <= inflight_nxt;
      md_cnt     <= hold ? md_cnt + CNT_W'(1) : '0;
      if (hold && (md_cnt == CNT_W'(MD_MAX - 1))) md_timeout_q <= 1'b1;
    end
  end

  assign hz.stall_d    = stall;
  assign hz.flush_fd   = redirect;
  assign hz.flush_dx   = redirect;
  assign hz.x_hold     = hold;
  assign hz.fwd_sel_a  = sel_a;
  assign hz.fwd_sel_b  = sel_b;
  assign hz.md_timeout = md_timeout_q;
  assign hz.inflight   = inflight_q;
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: expected outputs are queued with each
// D-stage stimulus and compared mid-cycle; a DEPTH=5 instance covers deep forwards.
module tb_pipe_hazard_ctrl;
  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  pipe_hazard_ctrl_if #(.REG_W(5), .SEL_W(3)) hz  ();
  pipe_hazard_ctrl_if #(.REG_W(5), .SEL_W(3)) hz5 ();

  pipe_hazard_ctrl #(.NREGS(32), .REG_W(5), .DEPTH(3), .SEL_W(3), .MD_MAX(64)) dut (
    .clock(clock), .reset(reset), .hz(hz)
  );
  pipe_hazard_ctrl #(.NREGS(32), .REG_W(5), .DEPTH(5), .SEL_W(3), .MD_MAX(64)) dut5 (
    .clock(clock), .reset(reset), .hz(hz5)
  );

  typedef struct packed {
    logic       valid;
    logic [4:0] rs1;
    logic       u1;
    logic [4:0] rs2;
    logic       u2;
    logic [4:0] rd;
    logic       wr;
    logic       ld;
    logic       mul;
  } d_t;

  typedef struct packed {
    logic [2:0] sa;
    logic [2:0] sb;
    logic       st;
    logic       fl;
    logic       ho;
    logic [3:0] inf;
    logic       tmo;
  } exp_t;

  localparam d_t NOP = '0;

  exp_t exp_q[$];
  int   tests  = 0;
  int   failed = 0;

  function automatic d_t ins(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                             input logic wr, input logic ld, input logic mul);
    d_t d;
    d = '{valid: 1'b1, rs1: rs1, u1: 1'b1, rs2: rs2, u2: 1'b1, rd: rd, wr: wr, ld: ld, mul: mul};
    return d;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      failed++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic score();
    exp_t e;
    check("queue_depth", exp_q.size(), 1);
    if (exp_q.size() == 0) return;
    e = exp_q.pop_front();
    check("fwd_sel_a",  hz.fwd_sel_a,  e.sa);
    check("fwd_sel_b",  hz.fwd_sel_b,  e.sb);
    check("stall_d",    hz.stall_d,    e.st);
    check("flush_fd",   hz.flush_fd,   e.fl);
    check("flush_dx",   hz.flush_dx,   e.fl);
    check("x_hold",     hz.x_hold,     e.ho);
    check("inflight",   hz.inflight,   e.inf);
    check("md_timeout", hz.md_timeout, e.tmo);
  endtask

  task automatic step(input d_t d, input logic redir, input logic mdd,
                      input logic [2:0] sa, input logic [2:0] sb,
                      input logic st, input logic fl, input logic ho,
                      input logic [3:0] inf, input logic tmo);
    @(negedge clock);
    hz.d_valid    = d.valid;
    hz.d_rs1      = d.rs1;
    hz.d_rs1_used = d.u1;
    hz.d_rs2      = d.rs2;
    hz.d_rs2_used = d.u2;
    hz.d_rd       = d.rd;
    hz.d_wr       = d.wr;
    hz.d_is_load  = d.ld;
    hz.d_is_multi = d.mul;
    hz.x_redirect = redir;
    hz.md_done    = mdd;
    exp_q.push_back('{sa: sa, sb: sb, st: st, fl: fl, ho: ho, inf: inf, tmo: tmo});
    #2 score();
  endtask

  task automatic drive5(input logic v, input logic [4:0] rs1, input logic [4:0] rd, input logic wr);
    @(negedge clock);
    hz5.d_valid    = v;
    hz5.d_rs1      = rs1;
    hz5.d_rs1_used = v;
    hz5.d_rd       = rd;
    hz5.d_wr       = wr;
    #2;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    d_t r;
    hz.d_valid = 0; hz.d_rs1 = '0; hz.d_rs1_used = 0; hz.d_rs2 = '0; hz.d_rs2_used = 0;
    hz.d_rd = '0; hz.d_wr = 0; hz.d_is_load = 0; hz.d_is_multi = 0;
    hz.x_redirect = 0; hz.md_done = 0;
    hz5.d_valid = 0; hz5.d_rs1 = '0; hz5.d_rs1_used = 0; hz5.d_rs2 = '0; hz5.d_rs2_used = 0;
    hz5.d_rd = '0; hz5.d_wr = 0; hz5.d_is_load = 0; hz5.d_is_multi = 0;
    hz5.x_redirect = 0; hz5.md_done = 0;
    repeat (2) @(negedge clock);
    reset = 1'b0;

    // reset state, then basic forwarding distance
    step(NOP,                   0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(ins(3, 1, 2, 1, 0, 0), 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(ins(4, 3, 3, 1, 0, 0), 0, 0, 1, 1, 0, 0, 0, 1, 0);
    step(NOP,                   0, 0, 0, 0, 0, 0, 0, 2, 0);
    step(ins(0, 3, 4, 0, 0, 0), 0, 0, 3, 2, 0, 0, 0, 2, 0);
    step(ins(0, 3, 4, 0, 0, 0), 0, 0, 0, 3, 0, 0, 0, 1, 0);
    // load-use: one-cycle stall, then forward from stage 2
    step(ins(5, 1, 0, 1, 1, 0), 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(ins(6, 5, 1, 1, 0, 0), 0, 0, 1, 0, 1, 0, 0, 1, 0);
    step(ins(6, 5, 1, 1, 0, 0), 0, 0, 2, 0, 0, 0, 0, 1, 0);
    // redirect beats load-use; the D instruction is not inserted
    step(ins(7, 0, 0, 1, 1, 0), 0, 0, 0, 0, 0, 0, 0, 2, 0);
    step(ins(8, 7, 6, 1, 0, 0), 1, 0, 1, 2, 0, 1, 0, 2, 0);
    step(ins(9, 7, 6, 1, 0, 0), 0, 0, 2, 3, 0, 0, 0, 2, 0);
    // r0 writers in every stage never hazard
    step(ins(0, 0, 0, 1, 1, 0), 0, 0, 0, 0, 0, 0, 0, 2, 0);
    step(ins(0, 0, 0, 1, 1, 0), 0, 0, 0, 0, 0, 0, 0, 2, 0);
    step(ins(0, 0, 0, 1, 0, 0), 0, 0, 0, 0, 0, 0, 0, 3, 0);
    step(ins(0, 0, 0, 0, 0, 0), 0, 0, 0, 0, 0, 0, 0, 3, 0);
    // multicycle hold for 17 cycles; redirect ignored while held
    step(ins(10, 1, 2, 1, 0, 1), 0, 0, 0, 0, 0, 0, 0, 2, 0);
    for (int i = 0; i < 17; i++)
      step(ins(11, 10, 0, 1, 0, 0), (i == 5), 0, 1, 0, 1, 0, 1, 2, 0);
    step(ins(11, 10, 0, 1, 0, 0), 0, 1, 1, 0, 0, 0, 0, 2, 0);
    r = ins(0, 10, 11, 0, 0, 0);
    r.u2 = 1'b0;
    step(r,                      0, 0, 2, 0, 0, 0, 0, 2, 0);
    // timeout: md_done never arrives
    step(ins(12, 0, 0, 1, 0, 1), 0, 0, 0, 0, 0, 0, 0, 2, 0);
    for (int i = 0; i < 64; i++)
      step(NOP,                  0, 0, 0, 0, 1, 0, 1, 2, 0);
    step(NOP,                    0, 0, 0, 0, 0, 0, 0, 2, 1);
    step(NOP,                    0, 0, 0, 0, 0, 0, 0, 1, 1);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    step(NOP,                    0, 0, 0, 0, 0, 0, 0, 0, 0);

    // DEPTH=5: producer reaches stage 5
    drive5(1, 0, 3, 1);
    check("d5_sel_insert", hz5.fwd_sel_a, 0);
    for (int i = 0; i < 4; i++) drive5(0, 0, 0, 0);
    drive5(1, 3, 0, 0);
    check("d5_sel_stage5", hz5.fwd_sel_a, 5);
    check("d5_stall",      hz5.stall_d,   0);
    check("d5_inflight",   hz5.inflight,  1);
    drive5(1, 3, 0, 0);
    check("d5_sel_retired", hz5.fwd_sel_a, 0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Parametrised hazard, bypass and stall controller for the in-order pipeline. It replaces the fixed 5-stage, always-stall decode logic.
- Tracks in-flight destination registers across DEPTH post-decode stages (stage 1 = X ... stage DEPTH = W) in a shift-register scoreboard.
- Each cycle, for the instruction in D, it produces per-operand forward selects, load-use stalls, multicycle-unit holds and branch-redirect flushes.
- Sits beside the decode stage; the datapath muxes consume its selects.

Parameters:
- NREGS, 32, number of architectural registers; register 0 is hard-wired zero and never hazards.
- REG_W, 5, register index width; must satisfy 2^REG_W >= NREGS.
- DEPTH, 3, tracked stages after D; legal range 2..6.
- SEL_W, 3, forward-select width; must satisfy 2^SEL_W > DEPTH.
- MD_MAX, 64, maximum cycles a multicycle op may hold X before timeout.

Ports:
- clock  in  1  master clock; all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- d_valid  in  1  D holds a real instruction
- d_rs1  in  REG_W  source A index
- d_rs1_used  in  1  source A is read
- d_rs2  in  REG_W  source B index
- d_rs2_used  in  1  source B is read
- d_rd  in  REG_W  destination index
- d_wr  in  1  D instruction writes d_rd
- d_is_load  in  1  D instruction is a load; its result is available from stage 2 onward
- d_is_multi  in  1  D instruction is a multicycle (mult/div) op
- x_redirect  in  1  stage-1 instruction resolved a taken branch/jump
- md_done  in  1  multicycle unit result ready this cycle
- stall_d  out  1  hold PC and F/D; insert bubble into stage 1
- flush_fd  out  1  squash F/D contents
- flush_dx  out  1  insert bubble into stage 1 instead of D instruction
- x_hold  out  1  freeze stages 1..DEPTH and everything upstream
- fwd_sel_a  out  SEL_W  0 = regfile; k = forward from stage k
- fwd_sel_b  out  SEL_W  same, for source B
- md_timeout  out  1  sticky: multicycle op exceeded MD_MAX
- inflight  out  SEL_W+1  count of valid writing entries in the scoreboard

Behaviour:
- Scoreboard: DEPTH entries of {valid, rd, wr, is_load, is_multi}.
- Normal cycle: entry k+1 <= entry k; entry DEPTH retires.
- Entry 1 is loaded with the D instruction when d_valid & ~stall_d & ~flush_dx & ~x_hold; otherwise entry 1 receives a bubble (valid=0).
- x_hold=1: all entries are frozen and no insertion occurs.
- Reset: all entries invalid, md counter=0, md_timeout=0.
  - Outputs after reset: stall_d=0, flush_fd=0, flush_dx=0, x_hold=0, fwd_sel_a=fwd_sel_b=0, inflight=0.
  - Reset mid-hold clears the hold on the next cycle.
- Match (per used source s):
  - Entry k matches when it is valid, wr=1, rd==s and s!=0.
  - fwd_sel = smallest matching k (youngest producer); 0 if no match.
  - fwd_sel is 0 when the source is unused or d_valid=0.
- Load-use: stall_d=1 when the youngest match is entry 1 with is_load=1. The stall lasts exactly 1 cycle; the next cycle forwards from stage 2.
- Multicycle:
  - x_hold=1 while entry 1 is valid, is_multi=1 and md_done=0.
  - When x_hold=1, stall_d=1 as well.
  - The cycle md_done=1 drops x_hold combinationally, and the pipeline advances on that edge.
  - An internal counter increments each held cycle and clears when not holding.
  - At MD_MAX held cycles, md_timeout sets (sticky until reset) and x_hold is forced to 0.
- Redirect:
  - x_redirect=1 with x_hold=0 gives flush_fd=1, flush_dx=1 and stall_d=0. Redirect beats load-use.
  - x_redirect is ignored while x_hold=1.
- All outputs except md_timeout and inflight are combinational from scoreboard state plus D inputs. md_timeout and inflight are registered.
- No width extension on indices; inflight saturates at DEPTH.

Test Plan:
- add r3 in D, then add r4,r3,r3 next cycle -> fwd_sel_a=fwd_sel_b=1. Two cycles later a reader of r3 gets sel=3 (W) with DEPTH=3; after that, sel=0.
- lw r5 followed immediately by add r6,r5,r1 -> stall_d=1 for 1 cycle, entry 1 bubble, then fwd_sel_a=2, stall_d=0.
- mul in stage 1, md_done asserted after 17 cycles -> x_hold=stall_d=1 for exactly 17 cycles, scoreboard unchanged, inflight constant; advance on the md_done edge.
- Load-use condition and x_redirect=1 in the same cycle -> stall_d=0, flush_fd=flush_dx=1, entry 1 becomes a bubble next cycle.
- Writes to r0 in all stages; D reads r0 -> fwd_sel=0, no stall. With DEPTH=5 parameterisation, a producer in stage 5 -> sel=5.
- md_done never asserts with MD_MAX=64 -> x_hold drops after 64 held cycles and md_timeout=1 stays set; reset -> md_timeout=0 and all outputs 0 on the next cycle.
